tetris_fall_scheduler: RTL and testbench
========================================

// Module: tetris_fall_scheduler
// PURPOSE
//  Sequences the tetris_engine fall input. Replaces the ad-hoc game_clock counter in the top level.
//  Issues single-cycle next_fall pulses from a level-dependent gravity timer, soft-drop (move_down) and hard-drop (drop).
//  Raises level as lines clear. Freezes on game_over. Sits between the input debouncers and tetris_engine.next_fall.
// PARAMETERS
//  CNT_W           26          width of gravity/drop counter
//  BASE_PERIOD     50_000_000  gravity period in clk cycles at level 0 (>= MIN_PERIOD)
//  PERIOD_STEP     4_000_000   period reduction per level
//  MIN_PERIOD      5_000_000   floor of gravity period (>= 2)
//  LINES_PER_LEVEL 10          cleared lines per level-up (1..15)
//  MAX_LEVEL       15          level saturation value (<= 15)
//  DROP_PERIOD     4           cycles between pulses while hard-dropping (>= 2)
// PORTS
//  clk            in   1   system clock
//  reset_game     in   1   asynchronous active-high reset
//  any_key        in   1   OR of all player buttons; starts the game
//  move_down      in   1   soft-drop request, one-cycle pulse
//  drop           in   1   hard-drop request, one-cycle pulse
//  fallen         in   1   engine: active piece locked
//  game_over      in   1   engine: game over, level-sensitive
//  lines_cleared  in   21  engine: running total of cleared lines
//  next_fall      out  1   one-cycle pulse to engine.next_fall
//  dropping       out  1   high while in DROP state
//  level          out  4   current level
//  state          out  2   IDLE=0 RUN=1 DROP=2 OVER=3, for debug
// BEHAVIOUR
//  Reset (async, any time incl. mid-drop): state=IDLE; next_fall=0; dropping=0; level=0.
//   Also clears counter, lines_in_level and prev_lines (prev_lines=0).
//  All outputs are registered; every output change appears the cycle after its cause.
//  period = max(BASE_PERIOD - level*PERIOD_STEP, MIN_PERIOD). Compute at CNT_W+4 bits; no underflow wrap.
//  Priority each cycle: game_over > fallen > drop > move_down > timer.
//  IDLE:
//   - No pulses; counter held at 0.
//   - any_key -> RUN.
//   - If any_key coincides with move_down or drop, that request is also acted on this cycle (pulse next cycle / DROP).
//  RUN:
//   - counter increments each cycle. When counter == period-1: next_fall=1 and counter=0.
//   - move_down: next_fall=1, counter=0. Coinciding with expiry gives one pulse only.
//   - drop: -> DROP, counter=0, no pulse this cycle.
//  DROP:
//   - dropping=1. counter counts DROP_PERIOD cycles; pulse on each wrap. First pulse DROP_PERIOD cycles after entry.
//   - move_down and drop are ignored.
//   - fallen -> RUN, counter=0. A pulse due the same cycle is suppressed.
//  Any state except IDLE, game_over=1: -> OVER, next_fall=0 from the next cycle. OVER is left only by reset.
//  fallen in RUN: counter=0, so a new piece gets a full period.
//  Level tracking (all states except IDLE):
//   - delta = lines_cleared - prev_lines (21-bit unsigned); prev_lines <= lines_cleared.
//   - Only delta in 1..4 is accepted. Any other nonzero delta (wrap, engine reset) resyncs prev_lines only; no level change.
//   - lines_in_level += delta; if the result >= LINES_PER_LEVEL, subtract LINES_PER_LEVEL and level++.
//   - Level saturates at MAX_LEVEL; lines_in_level keeps wrapping.
//   - At most one level-up per cycle. A new period applies from the next timer restart; the current count is not truncated.
// TESTING (BASE_PERIOD=20 PERIOD_STEP=4 MIN_PERIOD=8 LINES_PER_LEVEL=2 DROP_PERIOD=3)
//  1 Reset then idle 100 cycles -> next_fall never asserted, state=0, level=0.
//  2 any_key at cycle t, nothing else -> state=1; pulses spaced exactly 20 cycles, each 1 cycle wide.
//  3 move_down on the same cycle the timer expires -> exactly one pulse; next timer pulse 20 cycles later.
//  4 drop, fallen after 10 cycles -> dropping=1; pulses at +3,+6,+9; then RUN with a full 20-cycle wait.
//  5 lines_cleared 0->3 in one step, then 3->4 -> level=1 then 2. Spacing becomes 16, then 12. Ramp further to level 4+ -> spacing 8 (floor).
//  6 game_over mid-DROP, then reset_game asserted mid-cycle -> no pulses after game_over; state=3; async reset gives state=0 immediately.

Source files
------------

// File: rtl/tetris_fall_scheduler.sv
// Fall scheduler for the tetris engine: produces single-cycle next_fall pulses
// from a level-dependent gravity timer, soft-drop and hard-drop requests, and
// tracks the player level from the engine's running cleared-line total.
module tetris_fall_scheduler #(
    parameter int CNT_W           = 26,
    parameter int BASE_PERIOD     = 50_000_000,
    parameter int PERIOD_STEP     = 4_000_000,
    parameter int MIN_PERIOD      = 5_000_000,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 15,
    parameter int DROP_PERIOD     = 4
) (
    input  logic        clk,
    input  logic        reset_game,
    input  logic        any_key,
    input  logic        move_down,
    input  logic        drop,
    input  logic        fallen,
    input  logic        game_over,
    input  logic [20:0] lines_cleared,
    output logic        next_fall,
    output logic        dropping,
    output logic [3:0]  level,
    output logic [1:0]  state
);

    localparam int PW = CNT_W + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DROP = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               fall_q, fall_d;
    logic               dropping_q, dropping_d;
    logic [3:0]         level_q, level_d;
    logic [3:0]         lil_q, lil_d;
    logic [20:0]        prev_q, prev_d;

    logic [PW-1:0]      step_total;
    logic [PW-1:0]      period_now;
    logic               timer_expire;
    logic               drop_expire;
    logic [20:0]        delta;
    logic [4:0]         lil_sum;

    // Gravity period for the current level, clamped at the floor without wrapping.
    always_comb begin
        step_total = PW'(level_q) * PW'(PERIOD_STEP);
        if ((step_total + PW'(MIN_PERIOD)) > PW'(BASE_PERIOD)) begin
            period_now = PW'(MIN_PERIOD);
        end else begin
            period_now = PW'(BASE_PERIOD) - step_total;
        end
    end

    // The period is latched whenever the counter sits at zero, so a level-up
    // only takes effect at the next timer restart and never truncates a count.
    assign timer_expire = (counter_q == (period_q - 1'b1));
    assign drop_expire  = (counter_q == CNT_W'(DROP_PERIOD - 1));

    // Next-state, counter and pulse decision; priority game_over > fallen > drop > move_down > timer.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        fall_d    = 1'b0;
        period_d  = (counter_q == '0) ? CNT_W'(period_now) : period_q;
        unique case (state_q)
            S_IDLE: begin
                counter_d = '0;
                if (any_key) begin
                    if (drop) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_RUN;
                        fall_d  = move_down;
                    end
                end
            end
            S_RUN: begin
                if (game_over) begin
                    state_d   = S_OVER;
                    counter_d = '0;
                end else if (fallen) begin
                    counter_d = '0;
                end else if (drop) begin
                    state_d   = S_DROP;
                    counter_d = '0;
                end else if (move_down || timer_expire) begin
                    fall_d    = 1'b1;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            S_DROP: begin
                if (game_over) begin
                    state_d   = S_OVER;
                    counter_d = '0;
                end else if (fallen) begin
                    state_d   = S_RUN;
                    counter_d = '0;
                end else if (drop_expire) begin
                    fall_d    = 1'b1;
                    counter_d = '0;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            S_OVER: begin
                counter_d = '0;
            end
            default: begin
                state_d   = S_IDLE;
                counter_d = '0;
            end
        endcase
        dropping_d = (state_d == S_DROP);
    end

    // Level tracking from the engine's cleared-line total; implausible jumps only resync.
    always_comb begin
        delta   = lines_cleared - prev_q;
        lil_sum = 5'(lil_q) + 5'(delta[2:0]);
        prev_d  = prev_q;
        lil_d   = lil_q;
        level_d = level_q;
        if (state_q != S_IDLE) begin
            prev_d = lines_cleared;
            if ((delta >= 21'd1) && (delta <= 21'd4)) begin
                if (lil_sum >= 5'(LINES_PER_LEVEL)) begin
                    lil_d = 4'(lil_sum - 5'(LINES_PER_LEVEL));
                    if (level_q < 4'(MAX_LEVEL)) begin
                        level_d = level_q + 1'b1;
                    end
                end else begin
                    lil_d = lil_sum[3:0];
                end
            end
        end
    end

    // Control and timer registers.
    always_ff @(posedge clk or posedge reset_game) begin
        if (reset_game) begin
            state_q    <= S_IDLE;
            counter_q  <= '0;
            period_q   <= CNT_W'(BASE_PERIOD);
            fall_q     <= 1'b0;
            dropping_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            counter_q  <= counter_d;
            period_q   <= period_d;
            fall_q     <= fall_d;
            dropping_q <= dropping_d;
        end
    end

    // Level bookkeeping registers.
    always_ff @(posedge clk or posedge reset_game) begin
        if (reset_game) begin
            level_q <= '0;
            lil_q   <= '0;
            prev_q  <= '0;
        end else begin
            level_q <= level_d;
            lil_q   <= lil_d;
            prev_q  <= prev_d;
        end
    end

    assign next_fall = fall_q;
    assign dropping  = dropping_q;
    assign level     = level_q;
    assign state     = state_q;

endmodule

// File: tb/tb_tetris_fall_scheduler.sv
// Directed bench for tetris_fall_scheduler with small periods.
module tb_tetris_fall_scheduler;

    logic        clk = 1'b0;
    logic        reset_game = 1'b1;
    logic        any_key = 1'b0;
    logic        move_down = 1'b0;
    logic        drop = 1'b0;
    logic        fallen = 1'b0;
    logic        game_over = 1'b0;
    logic [20:0] lines_cleared = '0;
    logic        next_fall;
    logic        dropping;
    logic [3:0]  level;
    logic [1:0]  state;

    int total = 0;
    int bad   = 0;

    tetris_fall_scheduler #(
        .CNT_W(8), .BASE_PERIOD(20), .PERIOD_STEP(4), .MIN_PERIOD(8),
        .LINES_PER_LEVEL(2), .MAX_LEVEL(7), .DROP_PERIOD(3)
    ) dut (
        .clk(clk), .reset_game(reset_game), .any_key(any_key),
        .move_down(move_down), .drop(drop), .fallen(fallen),
        .game_over(game_over), .lines_cleared(lines_cleared),
        .next_fall(next_fall), .dropping(dropping), .level(level), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Ticks until next_fall is seen high; n = ticks taken, or -1 if the bound expires.
    task automatic wait_pulse(input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!next_fall && n < limit);
        if (!next_fall) n = -1;
    endtask

    initial begin
        int n;
        int cnt;

        // Reset and idle
        tick();
        tick();
        reset_game = 1'b0;
        check("rst_state", 32'(state), 0);
        check("rst_level", 32'(level), 0);
        check("rst_fall", 32'(next_fall), 0);
        check("rst_dropping", 32'(dropping), 0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (next_fall) cnt++;
        end
        check("idle_pulses", cnt, 0);
        check("idle_state", 32'(state), 0);

        // Start and gravity timing at level 0
        any_key = 1'b1;
        tick();
        any_key = 1'b0;
        check("start_state", 32'(state), 1);
        wait_pulse(40, n);
        check("first_gap", n, 20);
        tick();
        check("pulse_width", 32'(next_fall), 0);
        wait_pulse(40, n);
        check("second_gap", n, 19);

        // move_down coinciding with timer expiry
        repeat (19) tick();
        check("pre_expiry", 32'(next_fall), 0);
        move_down = 1'b1;
        tick();
        move_down = 1'b0;
        check("md_expiry_pulse", 32'(next_fall), 1);
        tick();
        check("md_single", 32'(next_fall), 0);
        wait_pulse(40, n);
        check("md_next_gap", n, 19);

        // Hard drop, move_down ignored, fallen after 10 cycles
        drop = 1'b1;
        tick();
        drop = 1'b0;
        check("drop_state", 32'(state), 2);
        check("drop_dropping", 32'(dropping), 1);
        check("drop_nopulse", 32'(next_fall), 0);
        move_down = 1'b1;
        tick();
        move_down = 1'b0;
        wait_pulse(10, n);
        check("drop_gap1", n, 2);
        wait_pulse(10, n);
        check("drop_gap2", n, 3);
        wait_pulse(10, n);
        check("drop_gap3", n, 3);
        fallen = 1'b1;
        tick();
        fallen = 1'b0;
        check("fallen_state", 32'(state), 1);
        check("fallen_dropping", 32'(dropping), 0);
        check("fallen_nopulse", 32'(next_fall), 0);
        wait_pulse(40, n);
        check("after_drop_gap", n, 20);

        // Level progression and period shrink
        lines_cleared = 21'd3;
        tick();
        check("level1", 32'(level), 1);
        wait_pulse(40, n);
        check("gap_untruncated", n, 19);
        wait_pulse(40, n);
        check("gap_lvl1", n, 16);
        lines_cleared = 21'd4;
        tick();
        check("level2", 32'(level), 2);
        wait_pulse(40, n);
        check("gap_lvl1b", n, 15);
        wait_pulse(40, n);
        check("gap_lvl2", n, 12);
        lines_cleared = 21'd6;
        tick();
        lines_cleared = 21'd8;
        tick();
        lines_cleared = 21'd10;
        tick();
        check("level5", 32'(level), 5);
        wait_pulse(40, n);
        check("gap_lvl2b", n, 9);
        wait_pulse(40, n);
        check("gap_floor", n, 8);

        // Implausible delta resync, then saturation
        lines_cleared = 21'd30;
        tick();
        check("big_delta", 32'(level), 5);
        lines_cleared = 21'd31;
        tick();
        check("after_resync", 32'(level), 5);
        lines_cleared = 21'd32;
        tick();
        check("level6", 32'(level), 6);
        lines_cleared = 21'd34;
        tick();
        check("level7", 32'(level), 7);
        lines_cleared = 21'd36;
        tick();
        check("level_sat", 32'(level), 7);

        // fallen in RUN restarts the timer
        tick();
        fallen = 1'b1;
        tick();
        fallen = 1'b0;
        wait_pulse(40, n);
        check("fallen_run_gap", n, 8);

        // game_over during DROP, on the cycle a drop pulse is due
        drop = 1'b1;
        tick();
        drop = 1'b0;
        repeat (5) tick();
        game_over = 1'b1;
        tick();
        check("over_state", 32'(state), 3);
        check("over_nopulse", 32'(next_fall), 0);
        check("over_dropping", 32'(dropping), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (next_fall) cnt++;
        end
        game_over = 1'b0;
        repeat (5) tick();
        check("over_pulses", cnt, 0);
        check("over_sticky", 32'(state), 3);

        // Asynchronous reset mid-cycle
        #3;
        reset_game = 1'b1;
        #1;
        check("async_state", 32'(state), 0);
        check("async_level", 32'(level), 0);
        tick();
        reset_game = 1'b0;

        // any_key with drop from IDLE; stale line total must not raise level
        tick();
        any_key = 1'b1;
        drop = 1'b1;
        tick();
        any_key = 1'b0;
        drop = 1'b0;
        check("idle_drop_state", 32'(state), 2);
        check("idle_drop_dropping", 32'(dropping), 1);
        wait_pulse(10, n);
        check("idle_drop_gap", n, 3);
        check("stale_lines_level", 32'(level), 0);

        // any_key with move_down from IDLE
        reset_game = 1'b1;
        tick();
        reset_game = 1'b0;
        any_key = 1'b1;
        move_down = 1'b1;
        tick();
        any_key = 1'b0;
        move_down = 1'b0;
        check("idle_md_state", 32'(state), 1);
        check("idle_md_pulse", 32'(next_fall), 1);
        wait_pulse(40, n);
        check("idle_md_gap", n, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
